pipelined_adder: RTL

//  Parametrised, pipelined add/subtract unit; next generation of the 4-bit ripple adder.

---
 rtl/adder_pkg.sv | 22 ++
 rtl/adder_slice.sv | 30 +++
 rtl/pipelined_adder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the pipelined add/subtract unit.
//   - MODE_ADD / MODE_SUB : encoding of the 'sub' mode input
//   - calc_stages()       : number of pipeline stages for a WIDTH/CHUNK pair
//   - chunk_fits()        : legality of a WIDTH/CHUNK pair (used at elaboration)
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    // WIDTH must be a non-zero multiple of CHUNK so every stage gets a full slice.
    function automatic bit chunk_fits(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// -----------------------------------------------------------------------------
// adder_slice
//   Combinational CHUNK-bit adder slice used once per pipeline stage.
//   Ports:
//     a, b      : CHUNK-bit operand slices (b already inverted for subtract)
//     ci        : carry into the slice
//     s         : CHUNK-bit slice sum
//     co        : carry out of the slice MSB
//     c_msb_in  : carry into the slice MSB (for signed overflow at the top slice)
// -----------------------------------------------------------------------------
module adder_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] total;

    assign total    = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    assign s        = total[CHUNK-1:0];
    assign co       = total[CHUNK];
    // The sum bit is a ^ b ^ carry-in, so the carry into the MSB falls out of it.
    assign c_msb_in = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//   Pipelined add/subtract unit. WIDTH-bit operands are processed CHUNK bits
//   per stage; the inter-slice carry is registered, so the critical path is one
//   CHUNK-bit adder regardless of WIDTH. Latency = WIDTH/CHUNK cycles.
//   Ports:
//     clk, rst_n           : rising-edge clock, asynchronous active-low reset
//     in_valid / in_ready  : input handshake for a, b, cin, sub
//     a, b                 : WIDTH-bit operands
//     cin                  : carry-in (add only; subtract forces carry-in = 1)
//     sub                  : MODE_ADD = a+b+cin, MODE_SUB = a-b
//     out_valid / out_ready: output handshake
//     sum                  : result modulo 2^WIDTH
//     cout                 : carry out of bit WIDTH-1 (subtract: 1 = no borrow)
//     ovf                  : two's-complement signed overflow
// -----------------------------------------------------------------------------
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    if (!chunk_fits(WIDTH, CHUNK)) begin : g_param_check
        $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // One global advance: the whole pipe moves or the whole pipe holds.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Subtract as a + ~b + 1; the caller's cin is ignored in that mode.
    assign b_eff    = (sub == MODE_SUB) ? ~b : b;
    assign cin_eff  = (sub == MODE_SUB) ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int  LO    = k * CHUNK;
        localparam int  RES_W = (k + 1) * CHUNK;
        localparam bit  LAST  = (k == STAGES - 1);

        logic             vld_in;
        logic             ci;
        logic [CHUNK-1:0] a_sl;
        logic [CHUNK-1:0] b_sl;
        logic [CHUNK-1:0] s_sl;
        logic             co;
        logic             c_msb;
        logic [RES_W-1:0] res_in;

        logic             vld_q;
        logic             carry_q;
        logic [RES_W-1:0] res_q;

        // Stage k input: ports for stage 0, otherwise the previous stage's registers.
        if (k == 0) begin : g_src
            assign vld_in = in_valid;
            assign ci     = cin_eff;
            assign a_sl   = a[CHUNK-1:0];
            assign b_sl   = b_eff[CHUNK-1:0];
            assign res_in = s_sl;
        end else begin : g_src
            assign vld_in = g_st[k-1].vld_q;
            assign ci     = g_st[k-1].carry_q;
            assign a_sl   = g_st[k-1].g_skew.a_up_q[CHUNK-1:0];
            assign b_sl   = g_st[k-1].g_skew.b_up_q[CHUNK-1:0];
            assign res_in = {s_sl, g_st[k-1].res_q};
        end

        adder_slice #(.CHUNK(CHUNK)) u_slice (
            .a        (a_sl),
            .b        (b_sl),
            .ci       (ci),
            .s        (s_sl),
            .co       (co),
            .c_msb_in (c_msb)
        );

        // Stage k register boundary: valid, carry and the low result slices so far.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q   <= 1'b0;
                carry_q <= 1'b0;
                res_q   <= '0;
            end else if (adv) begin
                vld_q   <= vld_in;
                carry_q <= co;
                res_q   <= res_in;
            end
        end

        // Operand bits not yet consumed travel alongside; they shrink by CHUNK per stage.
        if (!LAST) begin : g_skew
            logic [WIDTH-RES_W-1:0] a_up_in;
            logic [WIDTH-RES_W-1:0] b_up_in;
            logic [WIDTH-RES_W-1:0] a_up_q;
            logic [WIDTH-RES_W-1:0] b_up_q;

            if (k == 0) begin : g_first
                assign a_up_in = a[WIDTH-1:CHUNK];
                assign b_up_in = b_eff[WIDTH-1:CHUNK];
            end else begin : g_next
                assign a_up_in = g_st[k-1].g_skew.a_up_q[WIDTH-LO-1:CHUNK];
                assign b_up_in = g_st[k-1].g_skew.b_up_q[WIDTH-LO-1:CHUNK];
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    a_up_q <= a_up_in;
                    b_up_q <= b_up_in;
                end
            end
        end

        // Top slice: signed overflow is carry-into-MSB xor carry-out-of-MSB.
        if (LAST) begin : g_out
            logic ovf_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= c_msb ^ co;
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].vld_q;
    assign sum       = g_st[STAGES-1].res_q;
    assign cout      = g_st[STAGES-1].carry_q;
    assign ovf       = g_st[STAGES-1].g_out.ovf_q;

endmodule
